div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.

---
 rtl/div_unit_pkg.sv | 12 +
 rtl/div_unit.sv | 110 +++++++++++
 tb/tb_div_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared data-path widths and divider state codes for the EX-stage divider.
package div_unit_pkg;

  localparam int unsigned DataBus = 32;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {rem, quot} and
// holds the pipeline via stall_req until the result is ready.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DataBus
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               cancel,
  input  logic               ack,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy,
  output logic               stall_req
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_e         state, state_nxt;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   rem_q, quot_q, abs_b;
  logic               neg_q, neg_r;
  logic [2*WIDTH-1:0] result_q;

  logic               a_neg, b_neg, last, keep;
  logic [WIDTH-1:0]   abs_a_in, abs_b_in;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   rem_nxt, quot_nxt, rem_fix, quot_fix;

  always_comb begin
    a_neg    = signed_op & dividend[WIDTH-1];
    b_neg    = signed_op & divisor[WIDTH-1];
    abs_a_in = a_neg ? -dividend : dividend;
    abs_b_in = b_neg ? -divisor : divisor;
    last     = (count == CW'(WIDTH-1));

    // Shifted remainder needs one extra bit: an unsigned divisor can exceed 2^(WIDTH-1).
    shifted  = {rem_q, quot_q[WIDTH-1]};
    keep     = (shifted >= {1'b0, abs_b});
    rem_nxt  = keep ? WIDTH'(shifted - {1'b0, abs_b}) : shifted[WIDTH-1:0];
    quot_nxt = {quot_q[WIDTH-2:0], keep};

    quot_fix = neg_q ? -quot_nxt : quot_nxt;
    rem_fix  = neg_r ? -rem_nxt : rem_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: if (start && !cancel) state_nxt = (divisor == '0) ? DIV_DONE : DIV_RUN;
      DIV_RUN: begin
        if (cancel || !start) state_nxt = DIV_IDLE;
        else if (last)        state_nxt = DIV_DONE;
      end
      DIV_DONE: if (cancel || ack) state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_IDLE;
      count    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      abs_b    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        DIV_IDLE: begin
          if (state_nxt == DIV_RUN) begin
            quot_q <= abs_a_in;
            rem_q  <= '0;
            abs_b  <= abs_b_in;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            count  <= '0;
          end else if (state_nxt == DIV_DONE) begin
            result_q <= {dividend, {WIDTH{1'b1}}};
          end
        end
        DIV_RUN: begin
          if (state_nxt == DIV_RUN) begin
            rem_q  <= rem_nxt;
            quot_q <= quot_nxt;
            count  <= count + 1'b1;
          end else if (state_nxt == DIV_DONE) begin
            result_q <= {rem_fix, quot_fix};
          end
        end
        DIV_DONE: if (state_nxt == DIV_IDLE) result_q <= '0;
        default: result_q <= '0;
      endcase
    end
  end

  assign result    = result_q;
  assign ready     = (state == DIV_DONE);
  assign busy      = (state != DIV_IDLE);
  assign stall_req = start & ~ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed fix-up, divide-by-zero,
// cancel/abort, ack hold-off and asynchronous reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, signed_op, cancel, ack;
  logic [31:0] dividend, divisor;
  logic [63:0] result;
  logic        ready, busy, stall_req;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .ack       (ack),
    .result    (result),
    .ready     (ready),
    .busy      (busy),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one divide at the current negedge, count stall cycles until ready,
  // optionally hold ack low, then consume with ack and drop start.
  task automatic do_div(input string tag, input logic sop, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int exp_stall, input int hold);
    int n;
    start = 1'b1; signed_op = sop; dividend = a; divisor = b;
    #1;
    n = stall_req ? 1 : 0;
    @(negedge clk);
    dividend = ~a;
    divisor  = b ^ 32'h5;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, ":stalls"}, 64'(n), 64'(exp_stall));
    check({tag, ":result"}, result, exp);
    check({tag, ":stall_low"}, {63'd0, stall_req}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":hold_ready"}, {63'd0, ready}, 64'd1);
      check({tag, ":hold_result"}, result, exp);
    end
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    check({tag, ":idle_busy"}, {63'd0, busy}, 64'd0);
    check({tag, ":idle_result"}, result, 64'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; cancel = 1'b0; ack = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_stall", {63'd0, stall_req}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 0);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 0);
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 0);
    do_div("divu_bigb", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, {32'h7FFF_FFFE, 32'd1}, 33, 0);
    do_div("divu_ltb", 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'd0}, 33, 0);
    do_div("div0_u", 1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1, 0);
    do_div("div0_s", 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1, 0);

    // cancel at RUN cycle 10
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    repeat (9) @(negedge clk);
    check("cancel_pre_busy", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    check("cancel_busy", {63'd0, busy}, 64'd0);
    start = 1'b0; cancel = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (ready) seen++;
    end
    check("cancel_no_ready", 64'(seen), 64'd0);
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

    // start dropped mid-RUN aborts
    start = 1'b1; signed_op = 1'b1; dividend = 32'd50; divisor = 32'd3;
    @(negedge clk);
    repeat (4) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("squash_busy", {63'd0, busy}, 64'd0);

    // ack held low, then back-to-back issue the cycle after the ack edge
    do_div("hold", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 5);
    do_div("b2b", 1'b0, 32'd1001, 32'd10, {32'd1, 32'd100}, 33, 0);

    // asynchronous reset at RUN cycle 20
    start = 1'b1; signed_op = 1'b0; dividend = 32'd77; divisor = 32'd5;
    @(negedge clk);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_ready", {63'd0, ready}, 64'd0);
    check("arst_result", result, 64'd0);
    check("arst_stall", {63'd0, stall_req}, 64'd1);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    do_div("post_rst", 1'b0, 32'd77, 32'd5, {32'd2, 32'd15}, 33, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
